branch_ctrl: RTL

BRANCH_CTRL -- requirements
Module: branch_ctrl

---
 rtl/branch_ctrl_if.sv | 27 ++
 rtl/branch_ctrl.sv | 112 +++++++++++
 2 files changed

// File: rtl/branch_ctrl_if.sv
// Branch-control bus between the ID-stage hazard logic and the branch resolver.
// The master drives branch/operand status; the slave returns stall, decision and statistics.
interface branch_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic             br_valid;
    logic [1:0]       br_type;
    logic             opnd_ready;
    logic             equal;
    logic             clr_cnt;
    logic             stall;
    logic             npc_sel;
    logic             resolved;
    logic             err_timeout;
    logic [CNT_W-1:0] br_cnt;
    logic [CNT_W-1:0] taken_cnt;

    modport master (
        output br_valid, br_type, opnd_ready, equal, clr_cnt,
        input  stall, npc_sel, resolved, err_timeout, br_cnt, taken_cnt
    );

    modport slave (
        input  br_valid, br_type, opnd_ready, equal, clr_cnt,
        output stall, npc_sel, resolved, err_timeout, br_cnt, taken_cnt
    );
endinterface

// File: rtl/branch_ctrl.sv
// ID-stage conditional-branch resolver: waits for forwarded operands, issues a
// one-cycle registered decision, abandons after MAX_WAIT stalls and keeps statistics.
module branch_ctrl #(
    parameter int unsigned MAX_WAIT = 4,
    parameter int unsigned CNT_W    = 16
) (
    input  logic         clk,
    input  logic         reset,
    branch_ctrl_if.slave bus
);
    localparam int unsigned WCNT_W = $clog2(MAX_WAIT + 1);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t              state;
    logic [WCNT_W-1:0]   wait_cnt;
    logic                npc_sel;
    logic                resolved;
    logic                err_timeout;
    logic [CNT_W-1:0]    br_cnt;
    logic [CNT_W-1:0]    taken_cnt;

    logic                accept_c;
    logic                taken_c;
    logic                at_limit_c;
    logic                stall_c;

    // Decision inputs; at_limit_c marks the abandon cycle, where stall is released.
    always_comb begin
        accept_c   = bus.br_valid & bus.opnd_ready;
        at_limit_c = (state == WAIT) && (wait_cnt == WCNT_W'(MAX_WAIT));
        stall_c    = bus.br_valid & ~bus.opnd_ready & ~at_limit_c;
        taken_c    = 1'b0;
        case (bus.br_type)
            2'b00:   taken_c = bus.equal;
            2'b01:   taken_c = ~bus.equal;
            default: taken_c = 1'b0;
        endcase
    end

    // Operand-wait FSM with registered decision pulse and sticky timeout flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            npc_sel     <= 1'b0;
            resolved    <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            resolved <= 1'b0;
            npc_sel  <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept_c) begin
                        resolved <= 1'b1;
                        npc_sel  <= taken_c;
                    end else if (bus.br_valid) begin
                        state    <= WAIT;
                        wait_cnt <= WCNT_W'(1);
                    end
                end
                WAIT: begin
                    if (accept_c) begin
                        state    <= IDLE;
                        wait_cnt <= '0;
                        resolved <= 1'b1;
                        npc_sel  <= taken_c;
                    end else if (!bus.br_valid) begin
                        state    <= IDLE;
                        wait_cnt <= '0;
                    end else if (at_limit_c) begin
                        state       <= IDLE;
                        wait_cnt    <= '0;
                        err_timeout <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + WCNT_W'(1);
                    end
                end
                default: begin
                    state    <= IDLE;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

    // Statistics; a clear wins over a same-cycle increment.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            br_cnt    <= '0;
            taken_cnt <= '0;
        end else if (bus.clr_cnt) begin
            br_cnt    <= '0;
            taken_cnt <= '0;
        end else if (accept_c) begin
            br_cnt <= br_cnt + CNT_W'(1);
            if (taken_c) begin
                taken_cnt <= taken_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.stall       = stall_c;
    assign bus.npc_sel     = npc_sel;
    assign bus.resolved    = resolved;
    assign bus.err_timeout = err_timeout;
    assign bus.br_cnt      = br_cnt;
    assign bus.taken_cnt   = taken_cnt;
endmodule
